// File: rtl/teknofest_ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package teknofest_ram_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_e;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to ptr.
module rr_arbiter2
  import teknofest_ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) gnt = (ptr == PORT_DATA) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/teknofest_ram_arbiter.sv
// Arbitrates instruction-fetch and data masters onto one synchronous RAM.
// Writes complete in the grant cycle; reads return one cycle later.
module teknofest_ram_arbiter
  import teknofest_ram_arb_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int DATA_W    = NB_COL * COL_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_busy_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic [NB_COL-1:0] m0_wstrb_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic [NB_COL-1:0] m1_wstrb_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [DATA_W-1:0] ram_wr_data_o,
  output logic [NB_COL-1:0] ram_wr_strb_o,
  input  logic [DATA_W-1:0] ram_rd_data_i
);

  arb_state_e state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       owner_q, owner_d;

  logic [1:0] arb_req, gnt;
  logic       win;

  // Reset is gated in here so the combinational grant stays low while rst_i is high.
  assign arb_req = (state_q == IDLE && !prog_busy_i && !rst_i) ? {m1_req_i, m0_req_i} : 2'b00;

  rr_arbiter2 u_rr (
    .req (arb_req),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign win      = gnt[1];
  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  // NOTE: every output and next-state signal gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    ram_rd_en_o   = 1'b0;
    ram_wr_strb_o = '0;
    ram_rd_addr_o = m0_addr_i;
    ram_wr_addr_o = m0_addr_i;
    ram_wr_data_o = m0_wdata_i;
    m0_rvalid_o   = 1'b0;
    m1_rvalid_o   = 1'b0;
    m0_rdata_o    = '0;
    m1_rdata_o    = '0;

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          ptr_d         = ~win;
          ram_rd_addr_o = win ? m1_addr_i  : m0_addr_i;
          ram_wr_addr_o = win ? m1_addr_i  : m0_addr_i;
          ram_wr_data_o = win ? m1_wdata_i : m0_wdata_i;
          if (win ? m1_we_i : m0_we_i) begin
            ram_wr_strb_o = win ? m1_wstrb_i : m0_wstrb_i;
          end else begin
            ram_rd_en_o = 1'b1;
            owner_d     = win;
            state_d     = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // RAM data for the read issued last cycle; prog_busy_i cannot cancel it.
        state_d = IDLE;
        if (owner_q == PORT_DATA) begin
          m1_rvalid_o = 1'b1;
          m1_rdata_o  = ram_rd_data_i;
        end else begin
          m0_rvalid_o = 1'b1;
          m0_rdata_o  = ram_rd_data_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together on the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= PORT_IFETCH;
      owner_q <= PORT_IFETCH;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

endmodule
